// File: rtl/att_cfg_if.sv
// Configuration write port for att_pattern_gen: valid/ready handshake carrying
// one channel's mode, period and pattern.
interface att_cfg_if #(
    parameter int CHANNELS    = 4,
    parameter int PER_W       = 8,
    parameter int PATTERN_LEN = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   CFG_VALID;
    logic                   CFG_READY;
    logic [CH_W-1:0]        CFG_CH;
    logic [1:0]             CFG_MODE;
    logic [PER_W-1:0]       CFG_PERIOD;
    logic [PATTERN_LEN-1:0] CFG_PATTERN;

    modport master (
        output CFG_VALID, CFG_CH, CFG_MODE, CFG_PERIOD, CFG_PATTERN,
        input  CFG_READY
    );

    modport slave (
        input  CFG_VALID, CFG_CH, CFG_MODE, CFG_PERIOD, CFG_PATTERN,
        output CFG_READY
    );
endinterface

// File: rtl/att_pattern_gen.sv
// Multi-channel attention/LED driver: shared prescaled tick, per-channel
// OFF/ON/BLINK/PATTERN modes configured through a valid/ready write port.
module att_channel #(
    parameter int PER_W       = 8,
    parameter int PATTERN_LEN = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_i,
    input  logic                   wr_i,
    input  logic [1:0]             mode_i,
    input  logic [PER_W-1:0]       period_i,
    input  logic [PATTERN_LEN-1:0] pattern_i,
    output logic                   att_o
);
    localparam int IDX_W = $clog2(PATTERN_LEN);

    typedef enum logic [1:0] {M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_PAT = 2'd3} mode_e;

    mode_e                  mode_q, mode_d;
    logic [PER_W-1:0]       per_q, per_d;
    logic [PER_W-1:0]       cnt_q, cnt_d;
    logic [PATTERN_LEN-1:0] pat_q, pat_d;
    logic [IDX_W-1:0]       idx_q, idx_d, idx_nxt;
    logic                   att_q, att_d;

    always_comb begin
        mode_d  = mode_q;
        per_d   = per_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        att_d   = att_q;
        idx_nxt = idx_q + IDX_W'(1);
        // A write on a tick edge wins: the channel restarts and that tick is dropped.
        if (wr_i) begin
            mode_d = mode_e'(mode_i);
            per_d  = (period_i == '0) ? PER_W'(1) : period_i;
            pat_d  = pattern_i;
            cnt_d  = '0;
            idx_d  = '0;
            att_d  = (mode_i == 2'd0) ? 1'b0 : (mode_i == 2'd3) ? pattern_i[0] : 1'b1;
        end else if (tick_i && (mode_q == M_BLINK || mode_q == M_PAT)) begin
            if (cnt_q == per_q - PER_W'(1)) begin
                cnt_d = '0;
                if (mode_q == M_BLINK) begin
                    att_d = ~att_q;
                end else begin
                    idx_d = idx_nxt;
                    att_d = pat_q[idx_nxt];
                end
            end else begin
                cnt_d = cnt_q + PER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= M_OFF;
            per_q  <= PER_W'(1);
            cnt_q  <= '0;
            pat_q  <= '0;
            idx_q  <= '0;
            att_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            per_q  <= per_d;
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            idx_q  <= idx_d;
            att_q  <= att_d;
        end
    end

    assign att_o = att_q;
endmodule

module att_pattern_gen #(
    parameter int CHANNELS    = 4,
    parameter int PRESCALE    = 12000000,
    parameter int PER_W       = 8,
    parameter int PATTERN_LEN = 8
) (
    input  logic                CLK_MCO,
    input  logic                RST,
    att_cfg_if.slave            cfg,
    output logic [CHANNELS-1:0] ATT,
    output logic                TICK
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] presc_q, presc_d;
    logic            tick_q, tick_d;
    logic            ready_q, ready_d;
    logic            accept;

    assign accept = cfg.CFG_VALID & ready_q;

    always_comb begin
        tick_d  = (presc_q == PS_W'(PRESCALE - 1));
        presc_d = tick_d ? '0 : presc_q + PS_W'(1);
        // One commit cycle after every accept; out-of-range channels still handshake.
        ready_d = ~accept;
    end

    always_ff @(posedge CLK_MCO or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            ready_q <= ready_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        att_channel #(
            .PER_W      (PER_W),
            .PATTERN_LEN(PATTERN_LEN)
        ) u_ch (
            .clk      (CLK_MCO),
            .rst      (RST),
            .tick_i   (tick_q),
            .wr_i     (accept && (cfg.CFG_CH == CH_W'(g))),
            .mode_i   (cfg.CFG_MODE),
            .period_i (cfg.CFG_PERIOD),
            .pattern_i(cfg.CFG_PATTERN),
            .att_o    (ATT[g])
        );
    end

    assign cfg.CFG_READY = ready_q;
    assign TICK          = tick_q;
endmodule

// File: tb/tb_att_pattern_gen.sv
// Scoreboarded bench for att_pattern_gen: per-tick expected channel bits are
// queued by the stimulus and checked by a tick-driven monitor.
module tb_att_pattern_gen;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    att_cfg_if #(.CHANNELS(4), .PER_W(8), .PATTERN_LEN(8)) cfg ();
    att_cfg_if #(.CHANNELS(3), .PER_W(8), .PATTERN_LEN(8)) cfg2 ();

    logic [3:0] att;
    logic       tick;
    logic [2:0] att2;
    logic       tick2;

    att_pattern_gen #(.CHANNELS(4), .PRESCALE(4), .PER_W(8), .PATTERN_LEN(8)) dut (
        .CLK_MCO(CLK), .RST(RST), .cfg(cfg), .ATT(att), .TICK(tick)
    );

    // Odd channel count (so an out-of-range channel is encodable) and PRESCALE=1.
    att_pattern_gen #(.CHANNELS(3), .PRESCALE(1), .PER_W(8), .PATTERN_LEN(8)) dut2 (
        .CLK_MCO(CLK), .RST(RST), .cfg(cfg2), .ATT(att2), .TICK(tick2)
    );

    typedef struct {
        int    tick_no;
        int    ch;
        logic  bit_v;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_cnt = 0;
    logic tick_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int t, input int ch, input logic b, input string nm);
        exp_t e;
        e.tick_no = t; e.ch = ch; e.bit_v = b; e.name = nm;
        sb.push_back(e);
    endtask

    // tick_cnt = number of advance edges seen; entries for that tick are checked here.
    always @(negedge CLK) begin
        if (RST) begin
            tick_cnt  = 0;
            tick_seen = 1'b0;
        end else begin
            if (tick_seen) begin
                tick_cnt++;
                for (int i = sb.size() - 1; i >= 0; i--) begin
                    if (sb[i].tick_no == tick_cnt) begin
                        chk(sb[i].name, 32'(att[sb[i].ch]), 32'(sb[i].bit_v));
                        sb.delete(i);
                    end
                end
            end
            tick_seen = tick;
        end
    end

    task automatic wait_ticks(input int n);
        int target = tick_cnt + n;
        int guard  = 0;
        while (tick_cnt < target && guard < n * 4 + 20) begin
            @(negedge CLK); #1;
            guard++;
        end
        chk("wait_ticks_timeout", 32'(tick_cnt >= target), 32'd1);
    endtask

    // Single write on the main port, driven away from a tick edge.
    task automatic write(input int ch, input logic [1:0] mode, input logic [7:0] per,
                         input logic [7:0] pat, input logic exp_imm, input string nm);
        cfg.CFG_VALID   = 1'b1;
        cfg.CFG_CH      = 2'(ch);
        cfg.CFG_MODE    = mode;
        cfg.CFG_PERIOD  = per;
        cfg.CFG_PATTERN = pat;
        @(posedge CLK); #1;
        cfg.CFG_VALID = 1'b0;
        @(negedge CLK);
        chk({nm, "_ready_low"}, 32'(cfg.CFG_READY), 32'd0);
        chk({nm, "_att"}, 32'(att[ch]), 32'(exp_imm));
        @(negedge CLK);
        chk({nm, "_ready_back"}, 32'(cfg.CFG_READY), 32'd1);
    endtask

    initial begin
        int   t;
        logic blink_e [0:7];
        logic pat_e   [0:8];

        blink_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        pat_e   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        cfg.CFG_VALID = 1'b0; cfg.CFG_CH = '0; cfg.CFG_MODE = '0;
        cfg.CFG_PERIOD = '0; cfg.CFG_PATTERN = '0;
        cfg2.CFG_VALID = 1'b0; cfg2.CFG_CH = '0; cfg2.CFG_MODE = '0;
        cfg2.CFG_PERIOD = '0; cfg2.CFG_PATTERN = '0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_att", 32'(att), 32'h0);
        chk("rst_ready", 32'(cfg.CFG_READY), 32'd1);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_att2", 32'(att2), 32'h0);
        RST = 1'b0;

        // TICK first after edge 4 (cycle 5), then every 4; PRESCALE=1 stays high.
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK);
            chk("tick_start", 32'(tick), 32'((i == 4) || (i == 8)));
            chk("tick2_cont", 32'(tick2), 32'd1);
        end

        // Second instance: write ch0 ON, then a held out-of-range write to ch3.
        cfg2.CFG_VALID = 1'b1; cfg2.CFG_CH = 2'd0; cfg2.CFG_MODE = 2'd1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("d2_on_att", 32'(att2), 32'h1);
        chk("d2_ready_low", 32'(cfg2.CFG_READY), 32'd0);
        cfg2.CFG_CH = 2'd3; cfg2.CFG_MODE = 2'd1;
        @(posedge CLK); @(posedge CLK); #1;
        cfg2.CFG_VALID = 1'b0;
        @(negedge CLK);
        chk("d2_oob_accepted", 32'(cfg2.CFG_READY), 32'd0);
        chk("d2_oob_att", 32'(att2), 32'h1);

        // ch1 ON holds across 10 ticks; ch0 stays OFF.
        wait_ticks(1);
        t = tick_cnt;
        write(1, 2'd1, 8'd1, 8'h00, 1'b1, "on");
        for (int k = 1; k <= 10; k++) begin
            push(t + k, 1, 1'b1, "on_hold");
            push(t + k, 0, 1'b0, "off_hold");
        end
        wait_ticks(10);

        // ch0 BLINK period 2.
        t = tick_cnt;
        write(0, 2'd2, 8'd2, 8'h00, 1'b1, "blink");
        for (int k = 1; k <= 8; k++) push(t + k, 0, blink_e[k-1], "blink_seq");
        wait_ticks(8);

        // ch2 PATTERN 1011_0010 period 1, including wrap back to bit 0 and 1.
        t = tick_cnt;
        write(2, 2'd3, 8'd1, 8'b1011_0010, 1'b0, "pat");
        for (int k = 1; k <= 9; k++) push(t + k, 2, pat_e[k-1], "pat_seq");
        wait_ticks(9);

        // ch3 BLINK period 0 behaves as period 1.
        t = tick_cnt;
        write(3, 2'd2, 8'd0, 8'h00, 1'b1, "per0");
        for (int k = 1; k <= 4; k++) push(t + k, 3, 1'(k % 2 == 0), "per0_seq");
        wait_ticks(4);

        // Valid held across two queued writes: accepts exactly 2 cycles apart.
        t = tick_cnt;
        cfg.CFG_VALID = 1'b1; cfg.CFG_CH = 2'd0; cfg.CFG_MODE = 2'd2;
        cfg.CFG_PERIOD = 8'd1; cfg.CFG_PATTERN = 8'h00;
        @(posedge CLK); #1;
        cfg.CFG_CH = 2'd3; cfg.CFG_MODE = 2'd0;
        @(negedge CLK);
        chk("b2b_gap", 32'(cfg.CFG_READY), 32'd0);
        chk("b2b_first_att", 32'(att[0]), 32'd1);
        @(negedge CLK);
        chk("b2b_ready_back", 32'(cfg.CFG_READY), 32'd1);
        chk("b2b_not_yet", 32'(att[3]), 32'd1);
        @(posedge CLK); #1;
        cfg.CFG_VALID = 1'b0;
        @(negedge CLK);
        chk("b2b_second_accept", 32'(cfg.CFG_READY), 32'd0);
        chk("b2b_second_att", 32'(att[3]), 32'd0);
        push(t + 1, 0, 1'b0, "b2b_ch0");
        push(t + 1, 3, 1'b0, "b2b_ch3");
        wait_ticks(1);

        // Write to ch2 on a tick edge: ch2 restarts, ch0 still advances.
        t = tick_cnt;
        for (int k = 1; k <= 4; k++) begin
            push(t + k, 0, 1'(k % 2 == 1), "coin_ch0");
            push(t + k, 3, 1'b0, "coin_ch3");
        end
        push(t + 1, 2, 1'b0, "coin_ch2");
        push(t + 2, 2, 1'b1, "coin_ch2");
        push(t + 3, 2, 1'b1, "coin_ch2");
        push(t + 4, 2, 1'b0, "coin_ch2");
        repeat (3) @(negedge CLK);
        chk("coin_tick_pre", 32'(tick), 32'd1);
        #1;
        write(2, 2'd3, 8'd1, 8'b0000_0110, 1'b0, "coin");
        wait_ticks(4);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        // Reset during a pending commit cycle clears everything at once.
        cfg.CFG_VALID = 1'b1; cfg.CFG_CH = 2'd1; cfg.CFG_MODE = 2'd1;
        @(posedge CLK); #2;
        RST = 1'b1;
        cfg.CFG_VALID = 1'b0;
        #1;
        chk("rst_mid_att", 32'(att), 32'h0);
        chk("rst_mid_ready", 32'(cfg.CFG_READY), 32'd1);
        chk("rst_mid_tick", 32'(tick), 32'd0);
        chk("rst_mid_att2", 32'(att2), 32'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK);
            chk("tick_after_rst", 32'(tick), 32'(i == 4));
        end
        chk("att_after_rst", 32'(att), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
